// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the leaf async FIFO stages
// (memory, write pointer/full, write adapter).
//   DATA_WIDTH_DEF : default stream word width
//   CNT_WIDTH_DEF  : default statistics counter width
//   occ_e          : skid buffer occupancy (0, 1 or 2 words)
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_wr_adapter_if.sv
// fifo_wr_adapter_if: write-side stream and FIFO write bus.
//   in_valid/in_data/in_ready : upstream valid/ready stream
//   wfull                     : full flag from the write-pointer stage
//   winc/wdata                : write request and word to the FIFO
// slave  : the adapter's view.
// master : the surrounding environment (producer plus full stage).
interface fifo_wr_adapter_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  wfull;
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;

  modport slave (
    input  in_valid, in_data, wfull,
    output in_ready, winc, wdata
  );

  modport master (
    output in_valid, in_data, wfull,
    input  in_ready, winc, wdata
  );

endinterface

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry skid buffer with registered ready and head-valid.
//   wclk, wrst_n : clock, async active-low reset
//   push_valid/push_data/push_ready : input stream
//   pop_stall    : head is held when 1 (pop = head_valid && !pop_stall)
//   head_valid/head_data : oldest buffered word, both registered
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic                  pop_stall,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  occ_e                  occ_r;
  occ_e                  occ_n_s;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] head_n_s;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [DATA_WIDTH-1:0] tail_n_s;
  logic                  ready_r;
  logic                  valid_r;
  logic                  push_s;
  logic                  pop_s;

  assign push_s = push_valid && ready_r;
  assign pop_s  = (occ_r != OCC_0) && !pop_stall;

  // Next occupancy and head/tail contents from push/pop.
  always_comb begin
    occ_n_s  = occ_r;
    head_n_s = head_r;
    tail_n_s = tail_r;
    case ({push_s, pop_s})
      2'b10: begin
        case (occ_r)
          OCC_0: begin
            head_n_s = push_data;
            occ_n_s  = OCC_1;
          end
          OCC_1: begin
            tail_n_s = push_data;
            occ_n_s  = OCC_2;
          end
          default: occ_n_s = occ_r;
        endcase
      end
      2'b01: begin
        case (occ_r)
          OCC_1: occ_n_s = OCC_0;
          OCC_2: begin
            head_n_s = tail_r;
            occ_n_s  = OCC_1;
          end
          // Unreachable encoding: recover to empty.
          default: occ_n_s = OCC_0;
        endcase
      end
      2'b11: begin
        // Only reachable with one word: it leaves while the new one lands.
        if (occ_r == OCC_1) begin
          head_n_s = push_data;
        end else begin
          occ_n_s = occ_r;
        end
      end
      default: occ_n_s = occ_r;
    endcase
  end

  // Buffer state plus registered ready/valid derived from next occupancy.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      occ_r   <= OCC_0;
      head_r  <= {DATA_WIDTH{1'b0}};
      tail_r  <= {DATA_WIDTH{1'b0}};
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      occ_r   <= occ_n_s;
      head_r  <= head_n_s;
      tail_r  <= tail_n_s;
      ready_r <= (occ_n_s == OCC_0) || (occ_n_s == OCC_1);
      valid_r <= (occ_n_s != OCC_0);
    end
  end

  assign push_ready = ready_r;
  assign head_valid = valid_r;
  assign head_data  = head_r;

endmodule

// File: rtl/fifo_wr_adapter.sv
// fifo_wr_adapter: write-side ingress of the leaf async FIFO.
//   wclk, wrst_n : write clock, async active-low reset
//   bus          : stream in (in_valid/in_data/in_ready), FIFO write out
//                  (winc/wdata), full flag in (wfull)
//   wr_count     : words committed to the FIFO, wraps
//   stall_count  : cycles with winc=1 and wfull=1, saturates
// A word is committed on the same edge and condition (winc && !wfull)
// that the pointer stage uses to advance.
module fifo_wr_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  fifo_wr_adapter_if.slave     bus,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  logic                 pop_s;
  logic                 stall_s;
  logic [CNT_WIDTH-1:0] wr_count_r;
  logic [CNT_WIDTH-1:0] stall_count_r;

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .push_valid (bus.in_valid),
    .push_data  (bus.in_data),
    .push_ready (bus.in_ready),
    .pop_stall  (bus.wfull),
    .head_valid (bus.winc),
    .head_data  (bus.wdata)
  );

  assign pop_s   = bus.winc && !bus.wfull;
  assign stall_s = bus.winc && bus.wfull;

  // Commit counter (wrapping) and stall counter (saturating).
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wr_count_r    <= {CNT_WIDTH{1'b0}};
      stall_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (pop_s) begin
        wr_count_r <= wr_count_r + CNT_WIDTH'(1);
      end
      if (stall_s && (stall_count_r != {CNT_WIDTH{1'b1}})) begin
        stall_count_r <= stall_count_r + CNT_WIDTH'(1);
      end
    end
  end

  assign wr_count    = wr_count_r;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// tb_fifo_wr_adapter: directed plus random stimulus checked against a
// queue-based model of the write adapter.
module tb_fifo_wr_adapter;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] stall_count;

  always #5 wclk = ~wclk;

  fifo_wr_adapter_if #(.DATA_WIDTH(DW)) bus ();

  fifo_wr_adapter #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .bus         (bus),
    .wr_count    (wr_count),
    .stall_count (stall_count)
  );

  // Reference model: buffered words in order, plus counters.
  logic [DW-1:0] q[$];
  int            m_wr;
  int            m_stall;
  bit            m_started;
  logic [DW-1:0] src;
  bit            rand_data;

  int checks;
  int passes;
  int fails;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("winc", DW'(bus.winc), DW'(q.size() != 0));
    chk("in_ready", DW'(bus.in_ready), DW'(m_started && (q.size() < 2)));
    if (q.size() != 0) chk("wdata", bus.wdata, q[0]);
    chk("wr_count", DW'(wr_count), DW'(m_wr));
    chk("stall_count", DW'(stall_count), DW'(m_stall));
  endtask

  // One clock: update the model with the values present at the edge,
  // check at the falling edge, then present the next source word.
  task automatic step();
    bit push;
    bit pop;
    bit rdy;
    push = 1'b0;
    @(posedge wclk);
    if (wrst_n) begin
      rdy  = m_started && (q.size() < 2);
      push = bus.in_valid && rdy;
      pop  = (q.size() != 0) && !bus.wfull;
      if ((q.size() != 0) && bus.wfull && (m_stall < 15)) m_stall++;
      if (pop) begin
        void'(q.pop_front());
        m_wr = (m_wr + 1) % 16;
      end
      if (push) q.push_back(bus.in_data);
      m_started = 1'b1;
    end
    @(negedge wclk);
    check_all();
    if (push) src = rand_data ? DW'($urandom) : src + DW'(1);
    bus.in_data = src;
  endtask

  task automatic model_reset();
    q.delete();
    m_wr      = 0;
    m_stall   = 0;
    m_started = 1'b0;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    fails     = 0;
    rand_data = 1'b0;
    src       = '0;
    model_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.wfull    = 1'b0;

    // Reset state.
    repeat (2) @(negedge wclk);
    chk("rst_winc", DW'(bus.winc), DW'(0));
    chk("rst_wdata", bus.wdata, DW'(0));
    chk("rst_in_ready", DW'(bus.in_ready), DW'(0));
    chk("rst_wr_count", DW'(wr_count), DW'(0));
    chk("rst_stall_count", DW'(stall_count), DW'(0));
    wrst_n = 1'b1;
    repeat (3) step();
    chk("ready_after_release", DW'(bus.in_ready), DW'(1));

    // Back-to-back stream 1..8 with wfull low.
    src = DW'(1);
    bus.in_data  = src;
    bus.in_valid = 1'b1;
    repeat (8) step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("stream_wr_count", DW'(wr_count), DW'(8));

    // Full for 5 cycles while streaming 0xA0...
    src = DW'(32'hA0);
    bus.in_data  = src;
    bus.in_valid = 1'b1;
    bus.wfull    = 1'b1;
    repeat (5) step();
    chk("full_in_ready_low", DW'(bus.in_ready), DW'(0));
    chk("full_wdata_held", bus.wdata, DW'(32'hA0));
    bus.wfull = 1'b0;
    repeat (6) step();
    bus.in_valid = 1'b0;
    repeat (3) step();

    // wfull glitch between edges has no effect; held across an edge blocks.
    bus.in_valid = 1'b1;
    repeat (2) begin
      bus.wfull = 1'b1;
      #2;
      bus.wfull = 1'b0;
      step();
    end
    bus.wfull = 1'b1;
    step();
    bus.wfull = 1'b0;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();

    // Reset pulse with two words buffered.
    bus.in_valid = 1'b1;
    bus.wfull    = 1'b1;
    repeat (3) step();
    chk("pre_rst_in_ready", DW'(bus.in_ready), DW'(0));
    #2;
    wrst_n = 1'b0;
    #1;
    chk("mid_rst_winc", DW'(bus.winc), DW'(0));
    chk("mid_rst_wr_count", DW'(wr_count), DW'(0));
    chk("mid_rst_stall_count", DW'(stall_count), DW'(0));
    model_reset();
    bus.in_valid = 1'b0;
    bus.wfull    = 1'b0;
    step();
    wrst_n = 1'b1;
    step();
    src = DW'(32'h55);
    bus.in_data  = src;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("first_after_rst", bus.wdata, DW'(32'h55));
    step();
    chk("first_after_rst_count", DW'(wr_count), DW'(1));

    // Stall counter saturation.
    bus.in_valid = 1'b1;
    bus.wfull    = 1'b1;
    repeat (22) step();
    chk("stall_saturated", DW'(stall_count), DW'(4'hF));
    bus.wfull = 1'b0;

    // Random traffic, random data, random full and glitches.
    rand_data = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.wfull = 1'b1;
        #2;
        bus.wfull = 1'b0;
      end else begin
        bus.wfull = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.wfull    = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
